// File: rtl/vga_timing_pkg.sv
// Shared 640x480 @ 60 Hz VGA timing constants and helpers.
// The pixel generator reuses these for its MAX_X/MAX_Y and refresh-tick row.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int VGA_CLK_DIV   = 4;
  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int VGA_H_SYNC_START = VGA_H_DISPLAY + VGA_H_FRONT;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
  localparam int VGA_V_SYNC_START = VGA_V_DISPLAY + VGA_V_FRONT;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

  typedef logic [CNT_W-1:0] coord_t;

  // Inclusive window test, used for the active-low sync regions.
  function automatic logic in_window(coord_t value, coord_t lo, coord_t hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle from the sync generator to the monitor pins and the pixel generator.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   p_tick;
  logic   frame_tick;
  coord_t pixel_x;
  coord_t pixel_y;

  modport master (
    output hsync, vsync, video_on, p_tick, frame_tick, pixel_x, pixel_y
  );

  modport slave (
    input hsync, vsync, video_on, p_tick, frame_tick, pixel_x, pixel_y
  );

endinterface

// File: rtl/vga_sync_gen_counter.sv
// Modulo-M counter with enable; exposes its next value so callers can
// register derived signals in step with the count.
module mod_m_counter #(
  parameter int M = 4,
  parameter int W = (M > 1) ? $clog2(M) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count_q,
  output logic [W-1:0] count_d,
  output logic         max_tick
);

  localparam logic [W-1:0] LAST = W'(M - 1);

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign max_tick = (count_q == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel-rate divider plus horizontal/vertical counters,
// producing active-low syncs, video_on, coordinates and a frame tick.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = VGA_CLK_DIV,
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam coord_t H_VIS_END = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS_END = coord_t'(V_DISPLAY);
  localparam coord_t HS_START  = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_END    = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_START  = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_END    = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             div_unused;
  logic             p_tick;
  coord_t           h_q, h_d, v_q, v_d;
  logic             h_max, v_max, v_en;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_tick_q, frame_tick_d;

  mod_m_counter #(.M(CLK_DIV), .W(DIV_W)) u_pix_div (
    .clk      (clk),
    .reset    (reset),
    .en       (1'b1),
    .count_q  (div_q),
    .count_d  (div_d),
    .max_tick (p_tick)
  );

  assign div_unused = ^{div_q, div_d};

  mod_m_counter #(.M(H_TOTAL), .W(CNT_W)) u_h_count (
    .clk      (clk),
    .reset    (reset),
    .en       (p_tick),
    .count_q  (h_q),
    .count_d  (h_d),
    .max_tick (h_max)
  );

  assign v_en = p_tick & h_max;

  mod_m_counter #(.M(V_TOTAL), .W(CNT_W)) u_v_count (
    .clk      (clk),
    .reset    (reset),
    .en       (v_en),
    .count_q  (v_q),
    .count_d  (v_d),
    .max_tick (v_max)
  );

  // Syncs are decoded from the next counts so the registered pins line up
  // with pixel_x/pixel_y on the same clock, with no one-pixel lag.
  always_comb begin
    hsync_d      = ~in_window(h_d, HS_START, HS_END);
    vsync_d      = ~in_window(v_d, VS_START, VS_END);
    frame_tick_d = v_en & v_max;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.frame_tick = frame_tick_q;
  assign vga.p_tick     = p_tick;
  assign vga.pixel_x    = h_q;
  assign vga.pixel_y    = v_q;
  assign vga.video_on   = (h_q < H_VIS_END) && (v_q < V_VIS_END);

endmodule
